// File: rtl/dmem_bus_pkg.sv
// Shared types and defaults for the data-memory bus controller.
package dmem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int TIMEOUT_CYC_DEF = 256;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Cycle counter that flags expiry on its last allowed wait cycle.
module dmem_timeout_cnt #(
    parameter int CNT_W       = 9,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A zero timeout disables expiry entirely
    assign expire = en && (TIMEOUT_CYC != 0) && (cnt == LAST);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// LSU data-memory access controller: runs one request on a valid/ready bus,
// stalls the pipeline until completion, reports bus-error/timeout faults.
module dmem_bus_ctrl
    import dmem_bus_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_valid,
    input  logic            data_wen,
    input  logic [3:0]      data_wstrb,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] data_wdata,
    input  logic            flush,
    output logic [XLEN-1:0] data_rdata,
    output logic            data_ready,
    output logic            lsu_stall,
    output logic            lsu_fault,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [XLEN-1:0] bus_req_addr,
    output logic            bus_req_write,
    output logic [3:0]      bus_req_wstrb,
    output logic [XLEN-1:0] bus_req_wdata,
    input  logic            bus_rsp_valid,
    output logic            bus_rsp_ready,
    input  logic [XLEN-1:0] bus_rsp_rdata,
    input  logic            bus_rsp_err
);

    state_t state;
    logic   orphan;
    logic   err_q;
    logic   tmo_q;
    logic   tmo_en;
    logic   tmo_clr;
    logic   expire;

    assign tmo_en  = (state == REQ) || (state == RSP);
    assign tmo_clr = !tmo_en || ((state == REQ) && bus_req_ready);

    dmem_timeout_cnt #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            orphan        <= 1'b0;
            err_q         <= 1'b0;
            tmo_q         <= 1'b0;
            data_rdata    <= '0;
            bus_req_addr  <= '0;
            bus_req_write <= 1'b0;
            bus_req_wstrb <= '0;
            bus_req_wdata <= '0;
        end else begin
            // A late response to an abandoned access is swallowed here
            if (orphan && bus_rsp_valid) begin
                orphan <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (data_valid && !flush && !orphan) begin
                        bus_req_addr  <= {data_addr[XLEN-1:2], 2'b00};
                        bus_req_write <= data_wen;
                        bus_req_wstrb <= data_wstrb;
                        bus_req_wdata <= data_wdata;
                        err_q         <= 1'b0;
                        tmo_q         <= 1'b0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        if (bus_req_ready) begin
                            orphan <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (bus_req_ready) begin
                        state <= RSP;
                    end else if (expire) begin
                        tmo_q <= 1'b1;
                        state <= DONE;
                    end
                end
                RSP: begin
                    if (flush) begin
                        if (!bus_rsp_valid) begin
                            orphan <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (bus_rsp_valid) begin
                        if (!bus_req_write) begin
                            data_rdata <= bus_rsp_rdata;
                        end
                        err_q <= bus_rsp_err;
                        state <= DONE;
                    end else if (expire) begin
                        tmo_q  <= 1'b1;
                        orphan <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus_req_valid = (state == REQ);
    assign bus_rsp_ready = (state == RSP) || orphan;
    assign data_ready    = (state == DONE) && !flush;
    assign lsu_fault     = data_ready && (err_q || tmo_q);

    // Reset gates the stall so the pipeline is released immediately
    assign lsu_stall = !rst && !flush &&
                       (((state == IDLE) && data_valid) ||
                        (state == REQ) || (state == RSP));

endmodule
